// File: rtl/csr_watchdog.sv
// CSR-mapped watchdog: 4-register window, prescaled down-counter, fire pulse and sticky level output.
// Latency: writes visible on csr_do next cycle; wdt_fire registered, rises (TIMEOUT+1)*PRESCALE edges after enable/kick.
// Backpressure: none; every csr_we cycle is one write, reads are combinational from csr_a.
module csr_watchdog #(
    parameter logic [4:0]  BASE            = 5'h10,
    parameter logic [23:0] PRESCALE        = 24'd8000000,
    parameter logic [7:0]  DEFAULT_TIMEOUT = 8'h05,
    parameter logic [7:0]  KICK_MAGIC      = 8'h6b
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    output logic       wdt_fire,
    output logic       wdt_out
);

    logic        en;
    logic        lock;
    logic        oe;
    logic        fired;
    logic [7:0]  timeout;
    logic [7:0]  count;
    logic [23:0] presc;
    logic        fire_q;

    logic        in_win;
    logic        wr_ctrl;
    logic        wr_ctrl_ok;
    logic        wr_timeout;
    logic        kick;
    logic        tick;
    logic        expire;
    logic        en_n;
    logic        fired_clr;

    assign in_win     = (csr_a[4:2] == BASE[4:2]);
    assign wr_ctrl    = csr_we && in_win && (csr_a[1:0] == 2'd0);
    assign wr_ctrl_ok = wr_ctrl && !lock;
    assign wr_timeout = csr_we && in_win && (csr_a[1:0] == 2'd1) && !lock;
    assign kick       = csr_we && in_win && (csr_a[1:0] == 2'd2) && (csr_di == KICK_MAGIC) && en;
    assign fired_clr  = wr_ctrl && csr_di[7];
    assign en_n       = wr_ctrl_ok ? csr_di[0] : en;
    assign tick       = (presc == PRESCALE - 24'd1);
    // A kick or a same-edge disable both pre-empt an expiring tick.
    assign expire     = en && en_n && !kick && tick && (count == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            lock    <= 1'b0;
            oe      <= 1'b0;
            fired   <= 1'b0;
            timeout <= DEFAULT_TIMEOUT;
            count   <= DEFAULT_TIMEOUT;
            presc   <= 24'd0;
            fire_q  <= 1'b0;
        end else begin
            en     <= en_n;
            fire_q <= expire;
            fired  <= expire || (fired && !fired_clr);
            if (wr_ctrl_ok) begin
                lock <= lock || csr_di[1];
                oe   <= csr_di[2];
            end
            if (wr_timeout) begin
                timeout <= csr_di;
            end

            if (!en_n) begin
                // Idle counter mirrors TIMEOUT, including a write on this same edge.
                count <= wr_timeout ? csr_di : timeout;
                presc <= 24'd0;
            end else if (!en || kick) begin
                count <= timeout;
                presc <= 24'd0;
            end else begin
                presc <= tick ? 24'd0 : presc + 24'd1;
                if (tick) begin
                    count <= (count == 8'd0) ? timeout : count - 8'd1;
                end
            end
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (in_win) begin
            case (csr_a[1:0])
                2'd0:    csr_do = {fired, 4'b0000, oe, lock, en};
                2'd1:    csr_do = timeout;
                2'd2:    csr_do = 8'h00;
                default: csr_do = count;
            endcase
        end
    end

    assign wdt_fire = fire_q;
    assign wdt_out  = fired && oe;

endmodule

// File: tb/tb_csr_watchdog.sv
// Bench for csr_watchdog: elapsed-time reference model checked every cycle, directed scenarios, random CSR traffic.
module tb_csr_watchdog;

    localparam int P = 4;
    localparam logic [7:0] DEF   = 8'h05;
    localparam logic [7:0] MAGIC = 8'h6b;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic       wdt_fire;
    logic       wdt_out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fire_cnt = 0;
    bit chk_on = 1'b0;

    csr_watchdog #(
        .BASE(5'h10),
        .PRESCALE(24'd4),
        .DEFAULT_TIMEOUT(DEF),
        .KICK_MAGIC(MAGIC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .csr_a(csr_a),
        .csr_di(csr_di),
        .csr_we(csr_we),
        .csr_do(csr_do),
        .wdt_fire(wdt_fire),
        .wdt_out(wdt_out)
    );

    always #5 clk = ~clk;

    // Reference model: countdown derived from time elapsed since the last reload.
    bit       m_en, m_lock, m_oe, m_fired, m_fire;
    logic [7:0] m_to = DEF;
    int       load_cyc = 0;
    int       load_val = 5;

    function automatic logic [7:0] m_count();
        if (!m_en) return m_to;
        return 8'(load_val - (cyc - load_cyc) / P);
    endfunction

    function automatic logic [7:0] m_rd(input logic [4:0] a);
        if (a[4:2] != 3'b100) return 8'h00;
        case (a[1:0])
            2'd0:    return {m_fired, 4'b0000, m_oe, m_lock, m_en};
            2'd1:    return m_to;
            2'd2:    return 8'h00;
            default: return m_count();
        endcase
    endfunction

    always @(posedge clk) begin
        bit wa, cw, uw, tw, kk, f, nen;
        cyc = cyc + 1;
        if (rst) begin
            m_en = 0; m_lock = 0; m_oe = 0; m_fired = 0; m_fire = 0;
            m_to = DEF; load_cyc = cyc; load_val = int'(DEF);
        end else begin
            wa  = csr_we && (csr_a[4:2] == 3'b100);
            cw  = wa && (csr_a[1:0] == 2'd0);
            uw  = cw && !m_lock;
            tw  = wa && (csr_a[1:0] == 2'd1) && !m_lock;
            kk  = wa && (csr_a[1:0] == 2'd2) && (csr_di == MAGIC) && m_en;
            nen = uw ? csr_di[0] : m_en;
            f   = 0;
            if (m_en && nen) begin
                if (kk) begin
                    load_cyc = cyc; load_val = int'(m_to);
                end else if (cyc - load_cyc == (load_val + 1) * P) begin
                    f = 1; load_cyc = cyc; load_val = int'(m_to);
                end
            end else if (!m_en && nen) begin
                load_cyc = cyc; load_val = int'(m_to);
            end
            m_fire  = f;
            m_fired = f || (m_fired && !(cw && csr_di[7]));
            if (uw) begin
                m_lock = m_lock || csr_di[1];
                m_oe   = csr_di[2];
            end
            m_en = nen;
            if (tw) m_to = csr_di;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model csr_do", int'(csr_do), int'(m_rd(csr_a)));
            check("model wdt_fire", int'(wdt_fire), int'(m_fire));
            check("model wdt_out", int'(wdt_out), int'(m_fired && m_oe));
        end
        if (wdt_fire === 1'b1) fire_cnt = fire_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        step();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
        csr_a = a;
        #1;
        check(name, int'(csr_do), int'(exp));
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        int e, k, f0, mn, r;
        logic [4:0] a;
        logic [7:0] d;
        rst = 1'b1; csr_we = 1'b0; csr_a = 5'h10; csr_di = 8'h00;
        idle(2);
        rst = 1'b0;
        chk_on = 1'b1;

        // 1: reset values
        rd(5'h10, 8'h00, "rst ctrl");
        rd(5'h11, 8'h05, "rst timeout");
        rd(5'h12, 8'h00, "rst kick");
        rd(5'h13, 8'h05, "rst count");
        check("rst wdt_out", int'(wdt_out), 0);
        idle(20);
        check("rst no fire", fire_cnt, 0);

        // 2: timeout 2, enable with OE
        wr(5'h11, 8'h02);
        wr(5'h10, 8'h05);
        e = cyc;
        wait_to(e + 11); check("s2 fire E+11", int'(wdt_fire), 0);
        wait_to(e + 12); check("s2 fire E+12", int'(wdt_fire), 1);
        check("s2 wdt_out E+12", int'(wdt_out), 1);
        wait_to(e + 13); check("s2 fire E+13", int'(wdt_fire), 0);
        rd(5'h10, 8'h85, "s2 ctrl fired");
        wait_to(e + 23); check("s2 fire E+23", int'(wdt_fire), 0);
        wait_to(e + 24); check("s2 fire E+24", int'(wdt_fire), 1);

        // 3: periodic kicks keep it alive, bad magic is ignored
        do_rst();
        wr(5'h11, 8'h02);
        wr(5'h10, 8'h01);
        f0 = fire_cnt; mn = 255; k = cyc;
        repeat (12) begin
            csr_a = 5'h13;
            for (int i = 0; i < 7; i++) begin
                step();
                if (int'(csr_do) < mn) mn = int'(csr_do);
            end
            wr(5'h12, MAGIC);
            k = cyc;
        end
        check("s3 no fire while kicked", fire_cnt - f0, 0);
        check("s3 count min >= 1", int'(mn >= 1), 1);
        idle(3);
        wr(5'h12, 8'h6a);
        wait_to(k + 11); check("s3 fire K+11", int'(wdt_fire), 0);
        wait_to(k + 12); check("s3 fire K+12", int'(wdt_fire), 1);

        // 4: lock blocks CTRL[2:0] and TIMEOUT, FIRED clear still works
        do_rst();
        wr(5'h11, 8'h02);
        wr(5'h10, 8'h03);
        rd(5'h10, 8'h03, "s4 ctrl locked");
        wr(5'h10, 8'h00);
        wr(5'h11, 8'h09);
        rd(5'h10, 8'h03, "s4 ctrl after write");
        rd(5'h11, 8'h02, "s4 timeout after write");
        f0 = fire_cnt;
        for (int i = 0; i < 40 && fire_cnt == f0; i++) step();
        check("s4 fire seen", int'(fire_cnt != f0), 1);
        rd(5'h10, 8'h83, "s4 fired set");
        wr(5'h10, 8'h80);
        rd(5'h10, 8'h03, "s4 fired cleared");

        // 5: out-of-window accesses
        do_rst();
        wr(5'h08, 8'hff);
        rd(5'h08, 8'h00, "s5 read 0x08");
        rd(5'h1f, 8'h00, "s5 read 0x1f");
        rd(5'h10, 8'h00, "s5 ctrl");
        rd(5'h11, 8'h05, "s5 timeout");
        rd(5'h13, 8'h05, "s5 count");

        // 6: reset mid-countdown
        wr(5'h11, 8'h03);
        wr(5'h10, 8'h05);
        e = cyc;
        wait_to(e + 9);
        do_rst();
        rd(5'h10, 8'h00, "s6 ctrl");
        rd(5'h11, 8'h05, "s6 timeout");
        rd(5'h13, 8'h05, "s6 count");
        f0 = fire_cnt;
        idle(40);
        check("s6 no fire after rst", fire_cnt - f0, 0);

        // random CSR traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_rst();
            end else if (r < 30) begin
                a = ($urandom_range(0, 9) < 8) ? {3'b100, 2'($urandom_range(0, 3))} : 5'($urandom);
                case (a[1:0])
                    2'd0:    d = {1'($urandom), 4'b0000, 1'($urandom), 1'($urandom_range(0, 19) == 0),
                                  1'($urandom_range(0, 3) != 0)};
                    2'd1:    d = 8'($urandom_range(0, 3));
                    2'd2:    d = ($urandom_range(0, 3) != 0) ? MAGIC : 8'($urandom);
                    default: d = 8'($urandom);
                endcase
                wr(a, d);
            end else begin
                csr_a = 5'($urandom);
                step();
            end
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
